// File: rtl/lsu_pkg.sv
// Shared definitions for param_lsu: size codes, FSM state encoding and
// small decode helpers that depend only on the size code and DATA_W.
package lsu_pkg;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_D  = 3'd3;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;
    localparam logic [2:0] SZ_WU = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_e;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    // Doubleword only exists on a 64-bit bus; code 7 is never valid.
    function automatic logic size_legal(input logic [2:0] size, input int data_w);
        case (size)
            SZ_D:    return (data_w == 64);
            3'd7:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_low_mask(input logic [2:0] size);
        case (size)
            SZ_H, SZ_HU: return 3'b001;
            SZ_W, SZ_WU: return 3'b011;
            SZ_D:        return 3'b111;
            default:     return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] size_byte_mask(input logic [2:0] size);
        case (size)
            SZ_B, SZ_BU: return 8'h01;
            SZ_H, SZ_HU: return 8'h03;
            SZ_W, SZ_WU: return 8'h0F;
            SZ_D:        return 8'hFF;
            default:     return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_rd_extend.sv
// Load path: picks the addressed lane out of the memory word and
// sign- or zero-extends it to the full core width.
module lsu_rd_extend
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [2:0]        i_size,
    input  logic [OFF_W-1:0]  i_off,
    input  logic              i_legal,
    input  logic [DATA_W-1:0] i_rd,
    output logic [DATA_W-1:0] o_rd
);

    logic [DATA_W-1:0] w_shifted;

    assign w_shifted = i_rd >> {i_off, 3'b000};

    always_comb begin
        o_rd = '0;
        if (i_legal) begin
            case (i_size)
                SZ_B:    o_rd = DATA_W'($signed(w_shifted[7:0]));
                SZ_H:    o_rd = DATA_W'($signed(w_shifted[15:0]));
                SZ_W:    o_rd = DATA_W'($signed(w_shifted[31:0]));
                SZ_BU:   o_rd = DATA_W'(w_shifted[7:0]);
                SZ_HU:   o_rd = DATA_W'(w_shifted[15:0]);
                SZ_WU:   o_rd = DATA_W'(w_shifted[31:0]);
                SZ_D:    o_rd = w_shifted;
                default: o_rd = '0;
            endcase
        end
    end

endmodule

// File: rtl/param_lsu.sv
// Load/store unit between core and a single-port memory, 32- or 64-bit.
// Define PARAM_LSU_MISALIGN_EXC_EN to add misalign_o and reject misaligned accesses.
module param_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [2:0]            core_size_i,
    input  logic [ADDR_W-1:0]     core_addr_i,
    input  logic [DATA_W-1:0]     core_wd_i,
    output logic [DATA_W-1:0]     core_rd_o,
    output logic                  core_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [DATA_W-1:0]     mem_wd_o,
    input  logic [DATA_W-1:0]     mem_rd_i,
    input  logic                  mem_ready_i
`ifdef PARAM_LSU_MISALIGN_EXC_EN
    ,
    output logic                  misalign_o
`endif
);

    localparam int LANES = lane_count(DATA_W);
    localparam int OFF_W = $clog2(LANES);

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
            $error("param_lsu: DATA_W must be 32 or 64");
        end
    endgenerate

    lsu_state_e        r_state;
    logic [OFF_W-1:0]  w_off_raw;
    logic [OFF_W-1:0]  w_low;
    logic [OFF_W-1:0]  w_off;
    logic              w_legal;
    logic              w_ok;
    logic              w_issue;
    logic [LANES-1:0]  w_be;

    assign w_off_raw = core_addr_i[OFF_W-1:0];
    assign w_low     = OFF_W'(size_low_mask(core_size_i));
    assign w_off     = w_off_raw & ~w_low;
    assign w_legal   = size_legal(core_size_i, DATA_W);

`ifdef PARAM_LSU_MISALIGN_EXC_EN
    logic w_misaligned;
    assign w_misaligned = |(w_off_raw & w_low);
    assign w_ok         = w_legal & ~w_misaligned;
    assign misalign_o   = core_req_i & w_legal & w_misaligned & ~rst_i;
`else
    // Sub-size address bits are dropped: lanes follow the aligned offset.
    assign w_ok = w_legal;
`endif

    assign w_issue = core_req_i & w_ok & ~rst_i;

    assign mem_req_o    = w_issue;
    assign mem_we_o     = core_we_i & ~rst_i;
    assign mem_addr_o   = core_addr_i;
    assign core_stall_o = w_issue & ~((r_state == ST_BUSY) & mem_ready_i);

    assign w_be     = LANES'(size_byte_mask(core_size_i)) << w_off;
    assign mem_be_o = w_issue ? w_be : '0;

    always_comb begin
        mem_wd_o = core_wd_i;
        case (core_size_i)
            SZ_B, SZ_BU: mem_wd_o = {(LANES){core_wd_i[7:0]}};
            SZ_H, SZ_HU: mem_wd_o = {(LANES/2){core_wd_i[15:0]}};
            SZ_W, SZ_WU: mem_wd_o = {(DATA_W/32){core_wd_i[31:0]}};
            default:     mem_wd_o = core_wd_i;
        endcase
    end

    lsu_rd_extend #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_rd_extend (
        .i_size  (core_size_i),
        .i_off   (w_off),
        .i_legal (w_ok),
        .i_rd    (mem_rd_i),
        .o_rd    (core_rd_o)
    );

    // Dropping the request while BUSY abandons the access; a late ready is discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (core_req_i && w_ok) r_state <= ST_BUSY;
                ST_BUSY: if (!core_req_i || mem_ready_i) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/param_lsu.md
PARAM_LSU -- requirements
Module: param_lsu

Interface
REQ-001 Parameter DATA_W, default 32, memory/core data width; legal values 32 and 64 only.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 core_req_i  input  1  core requests a load/store this cycle.
REQ-006 core_we_i  input  1  1 = store, 0 = load.
REQ-007 core_size_i  input  3  access size/sign code (B=0, H=1, W=2, D=3, BU=4, HU=5, WU=6).
REQ-008 core_addr_i  input  ADDR_W  byte address.
REQ-009 core_wd_i  input  DATA_W  store data, right-aligned.
REQ-010 core_rd_o  output  DATA_W  load result, extended to DATA_W.
REQ-011 core_stall_o  output  1  core must hold PC and request while high.
REQ-012 mem_req_o, mem_we_o  output  1 each  memory request and write strobe.
REQ-013 mem_addr_o  output  ADDR_W  byte address to memory.
REQ-014 mem_be_o  output  DATA_W/8  byte-lane enables.
REQ-015 mem_wd_o  output  DATA_W  lane-replicated store data.
REQ-016 mem_rd_i  input  DATA_W  memory read bus, valid when mem_ready_i high.
REQ-017 mem_ready_i  input  1  memory completes the current request this cycle.

Function
REQ-018 FSM states IDLE and BUSY; IDLE->BUSY when core_req_i=1 and the access is legal; BUSY->IDLE when mem_ready_i=1; otherwise hold.
REQ-019 mem_req_o = core_req_i and the access is legal; mem_we_o = core_we_i; mem_addr_o = core_addr_i; all combinational.
REQ-020 core_stall_o = core_req_i and not (state==BUSY and mem_ready_i); minimum access latency 2 cycles; the stall is released in the completion cycle.
REQ-021 mem_ready_i in IDLE is ignored.
REQ-022 mem_be_o = size mask (B:1, H:2, W:4, D:8 consecutive lanes) shifted left by core_addr_i modulo DATA_W/8; all zero when mem_req_o=0.
REQ-023 mem_wd_o = low 8/16/32 bits of core_wd_i replicated across all lanes; D passes core_wd_i unchanged.
REQ-024 core_rd_o = mem_rd_i lane selected by the address offset, then sign-extended (B/H/W) or zero-extended (BU/HU/WU) to DATA_W; D returns the full word; computed combinationally.
REQ-025 Size code 3 with DATA_W=32, and size code 7, are illegal: no mem_req_o, no stall, core_rd_o=0.
REQ-026 WU with DATA_W=32 behaves as W.
REQ-027 Back-to-back requests: the cycle after completion, IDLE accepts a new core_req_i immediately.
REQ-028 A core_req_i deasserted while BUSY returns the FSM to IDLE next cycle; mem_ready_i in that cycle is discarded.

Reset
REQ-029 While rst_i=1: state goes to IDLE on the edge; core_stall_o, mem_req_o, mem_we_o and mem_be_o are forced 0; misalign_o is forced 0.
REQ-030 Reset in BUSY aborts the access; the first cycle after reset is IDLE.

Configuration
REQ-031 With PARAM_LSU_MISALIGN_EXC_EN defined: output port misalign_o (1 bit) is present; a misaligned access (H at odd address, W not on a 4-byte boundary, D not on an 8-byte boundary) issues no mem_req_o, no stall, and misalign_o=1 in the same cycle.
REQ-032 Without PARAM_LSU_MISALIGN_EXC_EN: misalign_o is absent; address bits below the access size are treated as zero for mem_be_o and lane selection, and mem_addr_o is unchanged.

Structure
REQ-033 Package lsu_pkg holds the size-code localparams, the FSM state enum and the lane-count function of DATA_W.
REQ-034 Sub-module lsu_rd_extend implements the combinational load lane select and extension (REQ-024).

Verification
REQ-035 DATA_W=32, LB at addr 0x103, mem_rd_i=0x80_00_00_00 with ready on cycle 2 -> stall 1 then 0, core_rd_o=0xFFFFFF80.
REQ-036 DATA_W=32, SH addr 0x102, core_wd_i=0x1234ABCD -> mem_be_o=4'b1100, mem_wd_o=0xABCDABCD, mem_we_o=1.
REQ-037 DATA_W=64, LWU addr 0x4, mem_rd_i=0xDEADBEEF_00000000 -> core_rd_o=0x00000000DEADBEEF; with LW -> 0xFFFFFFFFDEADBEEF.
REQ-038 mem_ready_i held low for 5 cycles -> core_stall_o stays 1 for 6 cycles; rst_i pulsed in cycle 3 -> stall and mem_req_o go to 0, FSM returns to IDLE.
REQ-039 With the macro defined, LW at 0x102 -> misalign_o=1, mem_req_o=0, stall 0; without the macro -> mem_be_o=4'b1111 and the access completes.
